hdlc_tx_sequencer: RTL and testbench

Sequences the HDLC controller's register bus to transmit frames. Accepts payload bytes on a valid/ready stream, writes them into the Tx buffer, starts transmission, polls Tx status until the frame completes or aborts, and reports the outcome. Sits between a packet source and the HDLC core's `Address`/`WriteEnable`/`ReadEnable`/`DataIn`/`DataOut` port, as sole bus master during Tx.

---
 rtl/hdlc_tx_sequencer_if.sv | 20 ++
 rtl/hdlc_tx_sequencer.sv | 110 +++++++++++
 tb/tb_hdlc_tx_sequencer.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/hdlc_tx_sequencer_if.sv
// hdlc_tx_sequencer_if: payload stream, abort/status and HDLC register bus bundle for hdlc_tx_sequencer
interface hdlc_tx_sequencer_if;
  logic       S_Valid, S_Ready, S_Last, Abort_Req;
  logic [7:0] S_Data;
  logic       Busy, Frame_Done, Frame_Aborted, Frame_Err;
  logic [7:0] Frame_Len;
  logic [2:0] Address;
  logic       WriteEnable, ReadEnable;
  logic [7:0] DataIn, DataOut;
  modport master (
    input  S_Valid, S_Data, S_Last, Abort_Req, DataOut,
    output S_Ready, Busy, Frame_Done, Frame_Aborted, Frame_Err, Frame_Len,
           Address, WriteEnable, ReadEnable, DataIn
  );
  modport slave (
    output S_Valid, S_Data, S_Last, Abort_Req, DataOut,
    input  S_Ready, Busy, Frame_Done, Frame_Aborted, Frame_Err, Frame_Len,
           Address, WriteEnable, ReadEnable, DataIn
  );
endinterface

// File: rtl/hdlc_tx_sequencer.sv
// hdlc_tx_sequencer: loads a payload into the HDLC Tx buffer, enables Tx and polls Tx_SC to completion; HDLC_TX_TIMEOUT_EN adds a poll watchdog
module hdlc_tx_sequencer #(
  parameter int MAX_FRAME      = 126,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input logic Clk,
  input logic Rst,
  hdlc_tx_sequencer_if.master b
);
  typedef enum logic [3:0] {IDLE, LOAD, START, ARM, WAIT, ABORT_W, DRAIN, DONE, ABORTED, ERR} state_t;
  typedef enum logic [1:0] {C_ABORT, C_OVF, C_TMO} cause_t;
  state_t     state_q, state_d;
  cause_t     cause_q, cause_d;
  logic [7:0] cnt_q, cnt_d, len_q, len_d, din_q, din_d;
  logic [2:0] addr_q, addr_d;
  logic       we_q, we_d, re_q, re_d, smp_q, smp_d;
  logic       rdy, acc, ovf, polling, tmo;
  assign rdy     = !Rst && (state_q == IDLE || state_q == LOAD || state_q == DRAIN);
  assign acc     = b.S_Valid && rdy;
  assign ovf     = acc && !b.S_Last && cnt_q == 8'(MAX_FRAME);
  assign polling = state_q == ARM || state_q == WAIT;
`ifdef HDLC_TX_TIMEOUT_EN
  logic [15:0] tmr_q, tmr_d;
  always_comb tmr_d = polling ? tmr_q + 16'd1 : 16'd0;
  assign tmo = polling && tmr_q == 16'(TIMEOUT_CYCLES);
  always_ff @(posedge Clk) tmr_q <= Rst ? 16'd0 : tmr_d;
`else
  assign tmo = 1'b0;
`endif
  always_comb begin
    state_d = state_q;
    cause_d = cause_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    addr_d  = addr_q;
    din_d   = din_q;
    we_d    = 1'b0;
    re_d    = 1'b0;
    smp_d   = re_q;
    case (state_q)
      IDLE: if (acc) begin
        state_d = b.S_Last ? START : LOAD;
        cnt_d   = 8'd1;
        {we_d, addr_d, din_d} = {1'b1, 3'd1, b.S_Data};
      end
      LOAD: if (ovf || b.Abort_Req) begin
        state_d = ABORT_W;
        cause_d = ovf ? C_OVF : C_ABORT;
      end else if (acc) begin
        state_d = b.S_Last ? START : LOAD;
        cnt_d   = cnt_q + 8'd1;
        {we_d, addr_d, din_d} = {1'b1, 3'd1, b.S_Data};
      end
      START: begin
        state_d = ARM;
        len_d   = cnt_q;
        {we_d, addr_d, din_d} = {1'b1, 3'd0, 8'h02};
      end
      ARM, WAIT: begin
        addr_d = 3'd0;
        if (smp_q && b.DataOut[3]) state_d = ABORTED;
        else if (smp_q && state_q == WAIT && b.DataOut[0]) state_d = DONE;
        else if (b.Abort_Req || tmo) begin
          state_d = ABORT_W;
          cause_d = b.Abort_Req ? C_ABORT : C_TMO;
        end else if (smp_q && !b.DataOut[0]) state_d = WAIT;
        re_d = !re_q && (state_d == ARM || state_d == WAIT);
      end
      ABORT_W: begin
        state_d = cause_q == C_ABORT ? ABORTED : cause_q == C_OVF ? DRAIN : ERR;
        {we_d, addr_d, din_d} = {1'b1, 3'd0, 8'h04};
      end
      DRAIN: if (acc && b.S_Last) state_d = ERR;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q <= IDLE;
      cause_q <= C_ABORT;
      cnt_q   <= 8'd0;
      len_q   <= 8'd0;
      addr_q  <= 3'd0;
      din_q   <= 8'd0;
      we_q    <= 1'b0;
      re_q    <= 1'b0;
      smp_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cause_q <= cause_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      addr_q  <= addr_d;
      din_q   <= din_d;
      we_q    <= we_d;
      re_q    <= re_d;
      smp_q   <= smp_d;
    end
  end
  assign b.S_Ready       = rdy;
  assign b.Busy          = state_q != IDLE;
  assign b.Frame_Done    = state_q == DONE;
  assign b.Frame_Aborted = state_q == ABORTED;
  assign b.Frame_Err     = state_q == ERR;
  assign b.Frame_Len     = len_q;
  assign b.Address       = addr_q;
  assign b.WriteEnable   = we_q;
  assign b.ReadEnable    = re_q;
  assign b.DataIn        = din_q;
endmodule

// File: tb/tb_hdlc_tx_sequencer.sv
// tb_hdlc_tx_sequencer: scoreboard bench with a scripted Tx_SC status model for hdlc_tx_sequencer
module tb_hdlc_tx_sequencer;
  logic clk = 1'b0, rst = 1'b1;
  int cyc = 0, last_cyc = 0, n_chk = 0, n_pass = 0;
  typedef struct {int kind; logic [2:0] addr; logic [7:0] data; int dly;} ev_t;
  ev_t exp_q[$];
  logic [7:0] scr[$];
  hdlc_tx_sequencer_if bif();
  hdlc_tx_sequencer #(.MAX_FRAME(4), .TIMEOUT_CYCLES(20)) dut (.Clk(clk), .Rst(rst), .b(bif));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk)
    if (rst) bif.DataOut <= 8'h00;
    else if (bif.ReadEnable) begin
      if (scr.size() != 0) bif.DataOut <= scr.pop_front();
      else bif.DataOut <= 8'h00;
    end
  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s actual=%h expected=%h", nm, act, exp);
  endtask
  task automatic ex(input int k, input logic [2:0] a, input logic [7:0] d, input int dly);
    ev_t e;
    e = '{kind: k, addr: a, data: d, dly: dly};
    exp_q.push_back(e);
  endtask
  task automatic take(input int k, input logic [2:0] a, input logic [7:0] d);
    ev_t e;
    n_chk++;
    if (exp_q.size() == 0) begin
      $display("FAIL sb_unexpected kind=%0d addr=%0d data=%h cycle=%0d", k, a, d, cyc);
      last_cyc = cyc;
      return;
    end
    e = exp_q.pop_front();
    if (e.kind != k || (k == 0 && (e.addr != a || e.data != d)) || (e.dly >= 0 && cyc - last_cyc != e.dly))
      $display("FAIL sb_event kind=%0d/%0d addr=%0d/%0d data=%h/%h gap=%0d/%0d (actual/expected)",
               k, e.kind, a, e.addr, d, e.data, cyc - last_cyc, e.dly);
    else n_pass++;
    last_cyc = cyc;
  endtask
  always @(negedge clk) begin
    if (bif.WriteEnable === 1'b1 && bif.ReadEnable === 1'b1) begin
      n_chk++;
      $display("FAIL strobe_overlap actual=both expected=exclusive cycle=%0d", cyc);
    end
    if (bif.WriteEnable === 1'b1) take(0, bif.Address, bif.DataIn);
    if (bif.Frame_Done === 1'b1) take(1, 3'd0, 8'd0);
    if (bif.Frame_Aborted === 1'b1) take(2, 3'd0, 8'd0);
    if (bif.Frame_Err === 1'b1) take(3, 3'd0, 8'd0);
  end
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic send(input logic [7:0] d, input logic last);
    int t = 0;
    bif.S_Valid = 1'b1;
    bif.S_Data  = d;
    bif.S_Last  = last;
    #1;
    while (!bif.S_Ready && t < 50) begin
      tick(1);
      t++;
    end
    chk("send_ready", {7'd0, bif.S_Ready}, 8'd1);
    @(posedge clk);
    #1;
    bif.S_Valid = 1'b0;
    bif.S_Last  = 1'b0;
  endtask
  task automatic wait_idle(input string nm);
    int t = 0;
    while (bif.Busy && t < 200) begin
      tick(1);
      t++;
    end
    chk({nm, "_idle"}, {7'd0, bif.Busy}, 8'd0);
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1);
  end
  initial begin
    bif.S_Valid = 1'b0;
    bif.S_Data = 8'h00;
    bif.S_Last = 1'b0;
    bif.Abort_Req = 1'b0;
    tick(3);
    chk("ready_in_reset", {7'd0, bif.S_Ready}, 8'd0);
    rst = 1'b0;
    #1;
    chk("rst_ready", {7'd0, bif.S_Ready}, 8'd1);
    chk("rst_busy", {7'd0, bif.Busy}, 8'd0);
    chk("rst_we", {7'd0, bif.WriteEnable}, 8'd0);
    chk("rst_re", {7'd0, bif.ReadEnable}, 8'd0);
    chk("rst_addr", {5'd0, bif.Address}, 8'd0);
    chk("rst_din", bif.DataIn, 8'd0);
    chk("rst_len", bif.Frame_Len, 8'd0);
    scr = '{8'h01, 8'h00, 8'h00, 8'h01};
    ex(0, 3'd1, 8'h7E, -1); ex(0, 3'd1, 8'h11, 1); ex(0, 3'd1, 8'hFF, 1);
    ex(0, 3'd0, 8'h02, 1); ex(1, 3'd0, 8'h00, 9);
    send(8'h7E, 1'b0); send(8'h11, 1'b0); send(8'hFF, 1'b1);
    wait_idle("t1");
    chk("t1_len", bif.Frame_Len, 8'd3);
    chk("t1_ready", {7'd0, bif.S_Ready}, 8'd1);
    ex(0, 3'd1, 8'hA0, -1); ex(0, 3'd1, 8'hA1, 1); ex(0, 3'd1, 8'hA2, 1); ex(0, 3'd1, 8'hA3, 1);
    ex(0, 3'd0, 8'h04, 2); ex(3, 3'd0, 8'h00, 1);
    for (int i = 0; i < 6; i++) send(8'hA0 + 8'(i), i == 5);
    wait_idle("t2");
    chk("t2_ready", {7'd0, bif.S_Ready}, 8'd1);
    ex(0, 3'd1, 8'h55, -1); ex(0, 3'd0, 8'h02, 1); ex(0, 3'd0, 8'h04, -1); ex(2, 3'd0, 8'h00, 0);
    send(8'h55, 1'b1);
    tick(8);
    chk("t3_busy_wait", {7'd0, bif.Busy}, 8'd1);
    bif.Abort_Req = 1'b1;
    tick(1);
    bif.Abort_Req = 1'b0;
    wait_idle("t3");
    chk("t3_ready", {7'd0, bif.S_Ready}, 8'd1);
    scr = '{8'h08};
    ex(0, 3'd1, 8'h66, -1); ex(0, 3'd0, 8'h02, 1); ex(2, 3'd0, 8'h00, 3);
    send(8'h66, 1'b1);
    wait_idle("t4");
    chk("t4_len", bif.Frame_Len, 8'd1);
    ex(0, 3'd1, 8'h10, -1); ex(0, 3'd1, 8'h20, 1);
    send(8'h10, 1'b0); send(8'h20, 1'b0);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    #1;
    chk("t5_we", {7'd0, bif.WriteEnable}, 8'd0);
    chk("t5_busy", {7'd0, bif.Busy}, 8'd0);
    chk("t5_addr", {5'd0, bif.Address}, 8'd0);
    chk("t5_din", bif.DataIn, 8'd0);
    chk("t5_len", bif.Frame_Len, 8'd0);
    chk("t5_ready", {7'd0, bif.S_Ready}, 8'd1);
    tick(5);
    scr = '{8'h00, 8'h01};
    ex(0, 3'd1, 8'h77, -1); ex(0, 3'd0, 8'h02, 1); ex(1, 3'd0, 8'h00, 5);
    send(8'h77, 1'b1);
    wait_idle("t5b");
    chk("t5b_len", bif.Frame_Len, 8'd1);
`ifdef HDLC_TX_TIMEOUT_EN
    ex(0, 3'd1, 8'h99, -1); ex(0, 3'd0, 8'h02, 1); ex(0, 3'd0, 8'h04, 22); ex(3, 3'd0, 8'h00, 0);
    send(8'h99, 1'b1);
    wait_idle("t6");
`endif
    tick(4);
    chk("sb_drained", 8'(exp_q.size()), 8'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
